// File: rtl/shiftleft_seq_pkg.sv
// Shared constants and types for the shiftleft_seq sequencer.
//   DataW   : operand/result width
//   ShamtW  : shift-amount width
//   state_e : sequencer state encoding; the unused code 2'd3 decodes to idle
package shiftleft_seq_pkg;

   localparam int unsigned DataW  = 32;
   localparam int unsigned ShamtW = 5;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

endpackage

// File: rtl/shiftleft_two.sv
// Fixed 2-bit logical left shift stage; zeros fill from bit 0.
//   data_i : value to shift
//   data_o : data_i << 2
module shiftleft_two
   import shiftleft_seq_pkg::*;
(
   input  logic [DataW-1:0] data_i,
   output logic [DataW-1:0] data_o
);

   assign data_o = {data_i[DataW-3:0], 2'b00};

endmodule

// File: rtl/shiftleft_seq.sv
// Multi-cycle logical left shifter: result = data_operand << ctrl_shiftamt, two bit positions
// per cycle with a final single-bit step for odd amounts.
//   clock         : rising-edge clock
//   reset         : synchronous, active-high
//   start         : request, accepted in idle or done only
//   data_operand  : value to shift, sampled on accept
//   ctrl_shiftamt : shift amount 0..31, sampled on accept
//   result        : working/result register, final from done until next accept
//   busy          : high while shifting
//   done          : one-cycle pulse when result is final
module shiftleft_seq
   import shiftleft_seq_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [DataW-1:0]  data_operand,
   input  logic [ShamtW-1:0] ctrl_shiftamt,
   output logic [DataW-1:0]  result,
   output logic              busy,
   output logic              done
);

   state_e             state_q, state_d;
   logic [DataW-1:0]   result_q, result_d;
   logic [ShamtW-1:0]  remaining_q, remaining_d;
   logic [DataW-1:0]   result_shl2;

   shiftleft_two u_shiftleft_two (
      .data_i (result_q),
      .data_o (result_shl2)
   );

   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      remaining_d = remaining_q;

      case (state_q)
         StShift: begin
            if (remaining_q >= ShamtW'(2)) begin
               result_d    = result_shl2;
               remaining_d = remaining_q - ShamtW'(2);
            end else if (remaining_q == ShamtW'(1)) begin
               result_d    = {result_q[DataW-2:0], 1'b0};
               remaining_d = '0;
            end
            // A zero count here can only come from a corrupted state; finish rather than hang.
            if (remaining_d == '0) begin
               state_d = StDone;
            end
         end
         // Idle, done, and the unused encoding all accept a new request or settle in idle.
         default: begin
            if (start) begin
               result_d    = data_operand;
               remaining_d = ctrl_shiftamt;
               state_d     = (ctrl_shiftamt == '0) ? StDone : StShift;
            end else begin
               state_d = StIdle;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         result_q    <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         remaining_q <= remaining_d;
      end
   end

   assign result = result_q;
   assign busy   = (state_q == StShift);
   assign done   = (state_q == StDone);

endmodule

// File: tb/tb_shiftleft_seq.sv
module tb_shiftleft_seq;

   logic        clock;
   logic        reset;
   logic        start;
   logic [31:0] data_operand;
   logic [4:0]  ctrl_shiftamt;
   logic [31:0] result;
   logic        busy;
   logic        done;

   int n_tests;
   int n_fail;

   shiftleft_seq dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .data_operand  (data_operand),
      .ctrl_shiftamt (ctrl_shiftamt),
      .result        (result),
      .busy          (busy),
      .done          (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; outputs are read 1ns after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Reference: after k shift cycles the register holds data << min(2k, n).
   function automatic logic [31:0] model_shl(input logic [31:0] d, input int sh);
      return (sh >= 32) ? 32'h0 : (d << sh);
   endfunction

   // Issue one operation in the current cycle and follow it to its done cycle.
   // poke re-asserts start with junk during the shift, which must be ignored.
   task automatic run_op(input logic [31:0] d, input int n, input bit poke, input string tag);
      int steps;
      int sh;
      start         = 1'b1;
      data_operand  = d;
      ctrl_shiftamt = n[4:0];
      step();
      start         = 1'b0;
      data_operand  = $urandom;
      ctrl_shiftamt = 5'($urandom);
      steps = (n + 1) / 2;
      for (int k = 0; k < steps; k++) begin
         sh = (2 * k < n) ? 2 * k : n;
         check_eq({tag, "_busy"}, 32'(busy), 32'd1);
         check_eq({tag, "_nodone"}, 32'(done), 32'd0);
         check_eq({tag, "_mid"}, result, model_shl(d, sh));
         if (poke) begin
            start         = 1'b1;
            data_operand  = 32'h12345678;
            ctrl_shiftamt = 5'($urandom);
         end
         step();
         start = 1'b0;
      end
      check_eq({tag, "_done"}, 32'(done), 32'd1);
      check_eq({tag, "_notbusy"}, 32'(busy), 32'd0);
      check_eq({tag, "_result"}, result, model_shl(d, n));
   endtask

   // Let the sequencer drop to idle and confirm the result is held.
   task automatic idle_check(input logic [31:0] exp, input string tag);
      start = 1'b0;
      step();
      check_eq({tag, "_idle_done"}, 32'(done), 32'd0);
      check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_idle_hold"}, result, exp);
   endtask

   initial begin
      logic [31:0] d;
      int          n;
      n_tests = 0;
      n_fail  = 0;

      // Reset held two cycles with start asserted: must be ignored.
      reset         = 1'b1;
      start         = 1'b1;
      data_operand  = 32'hFFFFFFFF;
      ctrl_shiftamt = 5'd3;
      step();
      step();
      check_eq("rst_result", result, 32'h0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      reset = 1'b0;
      start = 1'b0;
      step();
      check_eq("post_rst_busy", 32'(busy), 32'd0);
      check_eq("post_rst_done", 32'(done), 32'd0);
      check_eq("post_rst_result", result, 32'h0);

      run_op(32'h00000001, 5, 1'b0, "n5");
      idle_check(32'h00000020, "n5");

      run_op(32'hDEADBEEF, 0, 1'b0, "n0");
      idle_check(32'hDEADBEEF, "n0");

      run_op(32'hFFFFFFFF, 31, 1'b0, "n31");
      check_eq("n31_val", result, 32'h80000000);
      idle_check(32'h80000000, "n31");
      run_op(32'h80000001, 1, 1'b0, "n1");
      check_eq("n1_val", result, 32'h00000002);
      idle_check(32'h00000002, "n1");

      // Start during shift ignored; start in the done cycle accepted back-to-back.
      run_op(32'h00000001, 9, 1'b1, "poke");
      run_op(32'h00000003, 2, 1'b0, "b2b");
      check_eq("b2b_val", result, 32'h0000000C);
      idle_check(32'h0000000C, "b2b");

      // Reset mid-shift discards the operation without a done pulse.
      start         = 1'b1;
      data_operand  = 32'hA5A5A5A5;
      ctrl_shiftamt = 5'd20;
      step();
      start = 1'b0;
      for (int k = 0; k < 3; k++) step();
      check_eq("midrst_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("midrst_result", result, 32'h0);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      check_eq("midrst_done", 32'(done), 32'd0);
      step();
      check_eq("midrst_nodone", 32'(done), 32'd0);
      run_op(32'h00000001, 4, 1'b0, "after_rst");
      check_eq("after_rst_val", result, 32'h00000010);
      idle_check(32'h00000010, "after_rst");

      // Randomized operations, mixing back-to-back issue, idle gaps and pokes.
      for (int i = 0; i < 150; i++) begin
         d = $urandom;
         case ($urandom_range(0, 5))
            0:       n = 0;
            1:       n = 31;
            2:       n = 1;
            default: n = int'($urandom_range(0, 31));
         endcase
         run_op(d, n, bit'($urandom_range(0, 3) == 0), "rnd");
         if ($urandom_range(0, 2) != 0) begin
            idle_check(model_shl(d, n), "rnd");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
